figo_seq_gen: RTL and testbench
===============================

// Module: figo_seq_gen
// PURPOSE
//  Serial stimulus generator for the FIGO land-rover state FSM; drives its `inbit` input.
//  Keeps a shadow copy of the FSM state. On request it emits the shortest inbit sequence
//    that moves the FSM from its current state to a requested 3-bit target, then signals done.
//  Sits beside figo_fsm at the controller level:
//    - figo_seq_gen.inbit_o feeds figo_fsm.inbit.
//    - Both blocks are reset together; figo_fsm.reset = ~reset_n.
// PARAMETERS
//  IDLE_BIT   1'b0   inbit driven when no request is active (0 parks FSM in 0, 2 or 6)
//  CNT_W      4      width of path_len counter (longest shortest path is 4 bits)
// PORTS
//  clk         in   1      single clock, rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  req_valid   in   1      target request valid
//  req_ready   out  1      high when idle (not busy); request accepted on valid&ready edge
//  req_target  in   3      requested FSM state code
//  inbit_o     out  1      registered serial bit to FSM; FSM consumes it every clk edge
//  busy        out  1      path emission in progress
//  done        out  1      1-cycle pulse: shadow state == target (FSM reached target)
//  err         out  1      1-cycle pulse: target unreachable from current state, no bits sent
//  path_len    out  CNT_W  bits emitted for the last request; valid while done=1
//  cur_state   out  3      shadow FSM state (equals FSM state register every cycle)
// BEHAVIOUR
//  Reset (async, reset_n=0): cur_state=000, inbit_o=IDLE_BIT, busy=0, done=0, err=0, path_len=0.
//  Next-state function f(s,b), the same one figo_fsm implements:
//    0:1->1,0->0  1:1->2,0->3  2:1->3,0->2  3:1->4,0->5
//    4:1->5,0->6  5:1->7,0->6  6:1->7,0->6  7:1->3,0->4
//  Shadow tracking:
//    - nxt = f(cur_state, inbit_o), computed combinationally.
//    - cur_state <= nxt on every edge, busy or idle.
//  Reachability: reach(s,t) = t>=3, or (t==2 and s<=2), or (t==1 and s==0), or (t==s).
//  Routing: route(s,t) = first bit of the shortest path s->t.
//    - Ties go to the lexicographically smallest bit sequence (0 before 1).
//  Accept edge (req_valid & req_ready); the request is evaluated against nxt:
//    - Target unreachable: err<=1 for 1 cycle, stay idle, inbit_o<=IDLE_BIT.
//    - nxt==target: done<=1 for 1 cycle, path_len<=0, stay idle.
//    - Otherwise: latch target, busy<=1, inbit_o<=route(nxt,target), len counter<=1.
//  Each edge while busy:
//    - nxt==target: busy<=0, done<=1, path_len<=counter, inbit_o<=IDLE_BIT.
//    - Otherwise: inbit_o<=route(nxt,target), counter++.
//  done is high in exactly the cycle where cur_state==target.
//    - figo_fsm.detect shows the target one cycle later.
//  Idle: inbit_o=IDLE_BIT every cycle; shadow keeps tracking the FSM drift.
//  req_ready = ~busy, so it is high in the done cycle.
//    - A request accepted in the done cycle is evaluated against the post-idle-bit nxt.
//  req_valid while busy is ignored; no queuing.
//  Reset mid-path aborts immediately with no done or err. The FSM resets in the same instant.
//  done and err are never high together. A path never exceeds 4 bits; the counter must not wrap.
// STRUCTURE
//  Package figo_pkg:
//    - localparams ST_0..ST_7.
//    - functions figo_next(s,b), figo_reach(s,t), figo_route(s,t).
//    - figo_route is a 64-entry constant table, derived offline by BFS with the tie rule above.
//  Sub-module figo_route_rom: combinational {s,t} -> {reach, route_bit}, wrapping the package functions.
//  Top-level figo_seq_gen:
//    - 2-state control: IDLE / EMIT.
//    - shadow register, len counter, output registers.
// TESTING
//  1. Reset, idle 3 cycles -> inbit_o=0, cur_state stays 000.
//     Then req target 7 -> inbit_o 1,0,0,1; done when cur_state=7; path_len=4.
//  2. From state 0, req target 0 -> done the next cycle, path_len=0, busy never set, no bits.
//  3. From state 0, req target 6 -> bits 1,0,0,0; done; path_len=4.
//     Idle keeps state at 6. Then req target 5 -> bits 1,0,1; done at 5; path_len=3.
//  4. After test 1 (state 7->4 by idle), req target 2 -> err 1 cycle.
//     No busy; req_ready stays 1; cur_state follows idle drift.
//  5. reset_n low during the 2nd bit of the 0->7 path -> all outputs reset asynchronously.
//     Re-request 7 -> 1,0,0,1 again.
//  6. Random targets with back-to-back requests, incl. in the done cycle and req_valid held while busy.
//     Bench instantiates figo_fsm on inbit_o with reset=~reset_n.
//     Checks every cycle:
//       - cur_state == FSM state.
//       - detect == target on the cycle after done.
//       - path_len == BFS length.
//       - err exactly when the target is unreachable.

Source files
------------

// File: rtl/figo_pkg.sv
// Shared definitions for the FIGO stimulus generator: state codes,
// FSM transition function, reachability and first-bit routing.
package figo_pkg;

  localparam logic [2:0] ST_0 = 3'd0;
  localparam logic [2:0] ST_1 = 3'd1;
  localparam logic [2:0] ST_2 = 3'd2;
  localparam logic [2:0] ST_3 = 3'd3;
  localparam logic [2:0] ST_4 = 3'd4;
  localparam logic [2:0] ST_5 = 3'd5;
  localparam logic [2:0] ST_6 = 3'd6;
  localparam logic [2:0] ST_7 = 3'd7;

  // Bit {s,t} is the first bit of the shortest 0-first path s->t
  localparam logic [63:0] ROUTE_TBL = 64'h08B8_9820_10F8_04FE;

  typedef enum logic {
    CTL_IDLE = 1'b0,
    CTL_EMIT = 1'b1
  } ctl_t;

  function automatic logic [2:0] figo_next(
    input logic [2:0] s,
    input logic       b
  );
    logic [2:0] n;
    n = ST_0;
    unique case (s)
      ST_0: n = b ? ST_1 : ST_0;
      ST_1: n = b ? ST_2 : ST_3;
      ST_2: n = b ? ST_3 : ST_2;
      ST_3: n = b ? ST_4 : ST_5;
      ST_4: n = b ? ST_5 : ST_6;
      ST_5: n = b ? ST_7 : ST_6;
      ST_6: n = b ? ST_7 : ST_6;
      ST_7: n = b ? ST_3 : ST_4;
      default: n = ST_0;
    endcase
    return n;
  endfunction

  function automatic logic figo_reach(
    input logic [2:0] s,
    input logic [2:0] t
  );
    return (t >= ST_3)
        || (t == ST_2 && s <= ST_2)
        || (t == ST_1 && s == ST_0)
        || (t == s);
  endfunction

  function automatic logic figo_route(
    input logic [2:0] s,
    input logic [2:0] t
  );
    logic [5:0] idx;
    idx = {s, t};
    return ROUTE_TBL[idx];
  endfunction

endpackage

// File: rtl/figo_route_rom.sv
// Combinational route lookup: for a (state, target) pair gives
// whether the target is reachable and the next bit to send.
module figo_route_rom
  import figo_pkg::*;
(
  input  logic [2:0] i_s,
  input  logic [2:0] i_t,
  output logic       o_reach,
  output logic       o_route
);

  assign o_reach = figo_reach(i_s, i_t);
  assign o_route = figo_route(i_s, i_t);

endmodule

// File: rtl/figo_seq_gen.sv
// Serial stimulus generator: shadows the FIGO FSM and emits the
// shortest inbit sequence to a requested target state.
module figo_seq_gen
  import figo_pkg::*;
#(
  parameter logic IDLE_BIT = 1'b0,
  parameter int   CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_target,
  output logic             inbit_o,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] path_len,
  output logic [2:0]       cur_state
);

  ctl_t             r_ctl;
  ctl_t             w_ctl_nxt;
  logic [2:0]       r_state;
  logic [2:0]       r_tgt;
  logic             r_inbit;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;

  logic [2:0]       w_nxt;
  logic [2:0]       w_tgt;
  logic             w_reach;
  logic             w_route;
  logic             w_hit;
  logic             w_accept;
  logic             w_busy;

  // Requests are judged against the state the FSM lands in this edge
  assign w_nxt    = figo_next(r_state, r_inbit);
  assign w_tgt    = (r_ctl == CTL_IDLE) ? req_target : r_tgt;
  assign w_hit    = (w_nxt == w_tgt);
  assign w_accept = req_valid && (r_ctl == CTL_IDLE);

  figo_route_rom u_rom (
    .i_s     (w_nxt),
    .i_t     (w_tgt),
    .o_reach (w_reach),
    .o_route (w_route)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ctl <= CTL_IDLE;
    else          r_ctl <= w_ctl_nxt;
  end

  always_comb begin
    w_ctl_nxt = r_ctl;
    unique case (r_ctl)
      CTL_IDLE:
        if (w_accept && w_reach && !w_hit)
          w_ctl_nxt = CTL_EMIT;
      CTL_EMIT:
        if (w_hit)
          w_ctl_nxt = CTL_IDLE;
      default: w_ctl_nxt = CTL_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_ctl == CTL_EMIT);
    busy      = w_busy;
    req_ready = !w_busy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_0;
      r_tgt   <= ST_0;
      r_inbit <= IDLE_BIT;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_nxt;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      if (r_ctl == CTL_IDLE) begin
        r_inbit <= IDLE_BIT;
        if (w_accept) begin
          unique case (1'b1)
            !w_reach: r_err <= 1'b1;
            w_hit: begin
              r_done <= 1'b1;
              r_len  <= '0;
            end
            default: begin
              r_tgt   <= req_target;
              r_inbit <= w_route;
              r_cnt   <= CNT_W'(1);
            end
          endcase
        end
      end else begin
        if (w_hit) begin
          r_done  <= 1'b1;
          r_len   <= r_cnt;
          r_inbit <= IDLE_BIT;
        end else begin
          r_inbit <= w_route;
          if (r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign inbit_o   = r_inbit;
  assign done      = r_done;
  assign err       = r_err;
  assign path_len  = r_len;
  assign cur_state = r_state;

endmodule

// File: tb/tb_figo_seq_gen.sv
// Bench for figo_seq_gen: directed vector table, reset-abort
// sequence and random requests against a path-search model.
module tb_figo_seq_gen;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_target;
  logic       inbit_o;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] path_len;
  logic [2:0] cur_state;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [2:0] NT0 [8] = '{3'd0, 3'd3, 3'd2, 3'd5,
                                     3'd6, 3'd6, 3'd6, 3'd4};
  localparam logic [2:0] NT1 [8] = '{3'd1, 3'd2, 3'd3, 3'd4,
                                     3'd5, 3'd7, 3'd7, 3'd3};

  figo_seq_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .inbit_o    (inbit_o),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .path_len   (path_len),
    .cur_state  (cur_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] fnext(input logic [2:0] s,
                                       input logic b);
    return b ? NT1[s] : NT0[s];
  endfunction

  // Shortest path by exhaustive search in lexicographic order
  function automatic void spath(input logic [2:0] s,
                                input logic [2:0] t,
                                output bit ok,
                                output int len,
                                output logic [3:0] bits);
    logic [2:0] st;
    ok = 0; len = 0; bits = '0;
    for (int l = 0; l <= 4 && !ok; l++) begin
      for (int k = 0; k < (1 << l) && !ok; k++) begin
        st = s;
        for (int i = l - 1; i >= 0; i--) st = fnext(st, k[i]);
        if (st == t) begin
          ok = 1; len = l; bits = k[3:0];
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural FIGO FSM fed by the generator
  logic [2:0] fsm_st, fsm_det;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_st  <= 3'd0;
      fsm_det <= 3'd0;
    end else begin
      fsm_st  <= fnext(fsm_st, inbit_o);
      fsm_det <= fsm_st;
    end
  end

  logic [2:0] cur_tgt = 3'd0;
  bit         det_pend = 0;
  logic [2:0] det_tgt = 3'd0;
  always @(posedge clk) begin
    #2;
    if (!reset_n) begin
      det_pend = 0;
    end else begin
      chk("shadow", 32'(cur_state), 32'(fsm_st));
      chk("done_and_err", 32'(done & err), 0);
      if (det_pend) chk("detect", 32'(fsm_det), 32'(det_tgt));
      det_pend = done;
      det_tgt  = cur_tgt;
    end
  end

  task automatic chk_reset_outs();
    chk("rst_state", 32'(cur_state), 0);
    chk("rst_inbit", 32'(inbit_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_len", 32'(path_len), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_outs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_req(input int idle, input logic [2:0] tgt,
                         input bit hold, input bit e_err,
                         input int e_len, input logic [3:0] e_bits);
    repeat (idle) begin
      @(negedge clk);
      chk("idle_inbit", 32'(inbit_o), 0);
      chk("idle_ready", 32'(req_ready), 1);
    end
    chk("ready", 32'(req_ready), 1);
    req_valid  = 1'b1;
    req_target = tgt;
    cur_tgt    = tgt;
    @(negedge clk);
    if (!hold || e_err || e_len == 0) req_valid = 1'b0;
    else req_target = 3'($urandom_range(0, 7));
    if (e_err) begin
      chk("err", 32'(err), 1);
      chk("err_busy", 32'(busy), 0);
      chk("err_done", 32'(done), 0);
      chk("err_ready", 32'(req_ready), 1);
    end else begin
      for (int i = 0; i < e_len; i++) begin
        chk("emit_busy", 32'(busy), 1);
        chk("emit_bit", 32'(inbit_o), 32'(e_bits[e_len - 1 - i]));
        chk("emit_done", 32'(done), 0);
        chk("emit_err", 32'(err), 0);
        @(negedge clk);
        if (hold) req_target = 3'($urandom_range(0, 7));
      end
      req_valid = 1'b0;
      chk("done", 32'(done), 1);
      chk("path_len", 32'(path_len), 32'(e_len));
      chk("done_busy", 32'(busy), 0);
      chk("done_ready", 32'(req_ready), 1);
      chk("done_state", 32'(cur_state), 32'(tgt));
      chk("done_err", 32'(err), 0);
      chk("done_inbit", 32'(inbit_o), 0);
    end
    req_valid = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    int         idle;
    logic [2:0] tgt;
    bit         e_err;
    int         e_len;
    logic [3:0] e_bits;
  } vec_t;

  vec_t vt [11];

  initial begin
    bit         ok;
    int         len;
    logic [3:0] bits;
    logic [2:0] s;
    logic [2:0] tgt;
    int         idle;
    bit         hold;

    vt[0]  = '{1, 3, 3'd7, 0, 4, 4'b1001};
    vt[1]  = '{0, 1, 3'd2, 1, 0, 4'b0000};
    vt[2]  = '{0, 0, 3'd6, 0, 0, 4'b0000};
    vt[3]  = '{0, 2, 3'd5, 0, 3, 4'b0101};
    vt[4]  = '{0, 0, 3'd3, 0, 2, 4'b0011};
    vt[5]  = '{0, 0, 3'd0, 1, 0, 4'b0000};
    vt[6]  = '{0, 0, 3'd1, 1, 0, 4'b0000};
    vt[7]  = '{1, 1, 3'd0, 0, 0, 4'b0000};
    vt[8]  = '{0, 0, 3'd6, 0, 4, 4'b1000};
    vt[9]  = '{0, 3, 3'd6, 0, 0, 4'b0000};
    vt[10] = '{0, 0, 3'd5, 0, 3, 4'b0101};

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_target = 3'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      if (vt[v].rst) do_reset();
      run_req(vt[v].idle, vt[v].tgt, 0, vt[v].e_err,
              vt[v].e_len, vt[v].e_bits);
    end

    // Reset while the second bit of 0->7 is on the wire
    do_reset();
    req_valid  = 1'b1;
    req_target = 3'd7;
    cur_tgt    = 3'd7;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_bit1", 32'(inbit_o), 1);
    @(negedge clk);
    chk("abort_bit2", 32'(inbit_o), 0);
    chk("abort_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outs();
    chk("abort_ready", 32'(req_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    run_req(0, 3'd7, 0, 0, 4, 4'b1001);

    for (int r = 0; r < 60; r++) begin
      idle = int'($urandom_range(0, 2));
      tgt  = 3'($urandom_range(0, 7));
      hold = 1'($urandom_range(0, 1));
      s    = fsm_st;
      repeat (idle + 1) s = fnext(s, 1'b0);
      spath(s, tgt, ok, len, bits);
      run_req(idle, tgt, hold, !ok, len, bits);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
